// File: rtl/access_addr_correlator.sv
// BLE access-address correlator: hunts {AA, preamble} within a bit-error budget,
// then packs the following bits LSB-first into bytes for the packet decoder.
module access_addr_correlator #(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter int unsigned MAX_ERR     = 1,
  parameter int unsigned MAX_BYTES   = 42,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        sync_found,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [15:0] lock_count,
  output logic        timeout_flag
);

  localparam logic [7:0]  PRE = ACCESS_ADDR[0] ? 8'h55 : 8'hAA;
  localparam logic [39:0] SW  = {ACCESS_ADDR, PRE};
  localparam int          IW  = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [7:0]  BYTE_LAST = 8'(MAX_BYTES - 1);
  localparam logic [5:0]  ERR_LIM   = 6'(MAX_ERR);
  localparam logic [7:0]  MARKER    = ACCESS_ADDR[31:24];

  typedef enum logic [1:0] {
    SEARCH,
    RECEIVE,
    RELEASE
  } state_e;

  state_e        state_q;
  logic [39:0]   sr_q;
  logic [39:0]   sr_d;
  logic [5:0]    fill_q;
  logic [6:0]    bsr_q;
  logic [7:0]    byte_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    byte_cnt_q;
  logic [IW-1:0] idle_q;
  logic [5:0]    errs;
  logic          match;

  assign sr_d   = {bit_in, sr_q[39:1]};
  assign byte_d = {bit_in, bsr_q};

  always_comb begin
    errs = '0;
    for (int i = 0; i < 40; i++) begin
      errs = errs + {5'd0, sr_q[i] ^ SW[i]};
    end
  end

  // fill gate keeps a freshly cleared register from matching
  assign match = (fill_q == 6'd40) && (errs <= ERR_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      sr_q         <= '0;
      fill_q       <= '0;
      bsr_q        <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      idle_q       <= '0;
      sync_found   <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      lock_count   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      timeout_flag <= 1'b0;
      if (!enable) begin
        state_q    <= SEARCH;
        sync_found <= 1'b0;
        sr_q       <= '0;
        fill_q     <= '0;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        idle_q     <= '0;
      end else begin
        unique case (state_q)
          SEARCH: begin
            if (match) begin
              state_q    <= RECEIVE;
              sync_found <= 1'b1;
              data_out   <= MARKER;
              data_valid <= 1'b1;
              byte_cnt_q <= '0;
              idle_q     <= '0;
              if (lock_count != 16'hFFFF) begin
                lock_count <= lock_count + 16'd1;
              end
              if (bit_valid) begin
                bsr_q     <= byte_d[7:1];
                bit_cnt_q <= 3'd1;
              end else begin
                bit_cnt_q <= 3'd0;
              end
            end else if (bit_valid) begin
              sr_q <= sr_d;
              if (fill_q != 6'd40) begin
                fill_q <= fill_q + 6'd1;
              end
            end
          end
          RECEIVE: begin
            if (bit_valid) begin
              bsr_q     <= byte_d[7:1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              idle_q    <= '0;
              if (bit_cnt_q == 3'd7) begin
                data_out   <= byte_d;
                data_valid <= 1'b1;
                byte_cnt_q <= byte_cnt_q + 8'd1;
                if (byte_cnt_q == BYTE_LAST) begin
                  state_q <= RELEASE;
                end
              end
            end else if (idle_q == IDLE_LAST) begin
              state_q      <= SEARCH;
              timeout_flag <= 1'b1;
              sync_found   <= 1'b0;
              sr_q         <= '0;
              fill_q       <= '0;
              bit_cnt_q    <= '0;
              idle_q       <= '0;
            end else begin
              idle_q <= idle_q + IW'(1);
            end
          end
          RELEASE: begin
            state_q    <= SEARCH;
            sync_found <= 1'b0;
            sr_q       <= '0;
            fill_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
          end
          default: begin
            state_q <= SEARCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_access_addr_correlator.sv
// Bench for access_addr_correlator: random stimulus against a queue-based
// per-clock reference model, plus directed lock/timeout/enable/reset cases.
module tb_access_addr_correlator;

  localparam int MAX_BYTES = 42;
  localparam int TIMEOUT   = 64;
  localparam int MAX_ERR   = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        bit_in;
  logic        bit_valid;
  logic        sync_found;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [15:0] lock_count;
  logic        timeout_flag;

  int n_tests = 0;
  int n_fail  = 0;

  logic [39:0] sw;
  bit          m_win[$];
  bit          m_bits[$];
  int          m_mode;
  int          m_nbytes;
  int          m_idle;
  int          m_lock;
  logic        m_sync;
  logic        m_dv;
  logic        m_to;
  logic [7:0]  m_dout;
  logic [7:0]  got_q[$];
  bit          pdu[MAX_BYTES*8];

  access_addr_correlator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .sync_found   (sync_found),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .lock_count   (lock_count),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int win_dist();
    int d = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_win[i] != sw[i]) d++;
    end
    return d;
  endfunction

  function automatic void model_reset();
    m_win.delete();
    m_bits.delete();
    m_mode = 0;
    m_nbytes = 0;
    m_idle = 0;
    m_lock = 0;
    m_sync = 1'b0;
    m_dv = 1'b0;
    m_to = 1'b0;
    m_dout = 8'h00;
  endfunction

  // mode: 0 hunting, 1 locked, 2 one-clock release
  function automatic void model_step(input logic en, input logic v,
                                     input logic b);
    m_dv = 1'b0;
    m_to = 1'b0;
    if (!en) begin
      m_mode = 0;
      m_sync = 1'b0;
      m_win.delete();
      m_bits.delete();
      m_nbytes = 0;
      m_idle = 0;
    end else if (m_mode == 0) begin
      if (m_win.size() == 40 && win_dist() <= MAX_ERR) begin
        m_mode = 1;
        m_sync = 1'b1;
        m_dv = 1'b1;
        m_dout = 8'h8E;
        if (m_lock < 65535) m_lock++;
        m_nbytes = 0;
        m_idle = 0;
        m_bits.delete();
        if (v) m_bits.push_back(b);
      end else if (v) begin
        m_win.push_back(b);
        if (m_win.size() > 40) void'(m_win.pop_front());
      end
    end else if (m_mode == 1) begin
      if (v) begin
        m_idle = 0;
        m_bits.push_back(b);
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) m_dout[i] = m_bits[i];
          m_bits.delete();
          m_dv = 1'b1;
          m_nbytes++;
          if (m_nbytes == MAX_BYTES) m_mode = 2;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_to = 1'b1;
          m_sync = 1'b0;
          m_win.delete();
          m_bits.delete();
          m_mode = 0;
        end
      end
    end else begin
      m_sync = 1'b0;
      m_win.delete();
      m_mode = 0;
    end
  endfunction

  task automatic cycle(input logic en, input logic v, input logic b);
    enable = en;
    bit_valid = v;
    bit_in = b;
    @(posedge clk);
    model_step(en, v, b);
    #1;
    chk("sync_found", 32'(sync_found), 32'(m_sync));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    if (m_dv) chk("data_out", 32'(data_out), 32'(m_dout));
    chk("timeout_flag", 32'(timeout_flag), 32'(m_to));
    chk("lock_count", 32'(lock_count), 32'(m_lock));
    if (data_valid) got_q.push_back(data_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic drop();
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b, input bit gap);
    if (gap && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    cycle(1'b1, 1'b1, b);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic send_sync(input logic [39:0] mask, input bit gap);
    logic [39:0] w;
    w = sw ^ mask;
    for (int i = 0; i < 40; i++) send_bit(w[i], gap);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    enable = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_sync", 32'(sync_found), 32'(0));
    chk("rst_dv", 32'(data_valid), 32'(0));
    chk("rst_dout", 32'(data_out), 32'(0));
    chk("rst_lock", 32'(lock_count), 32'(0));
    chk("rst_to", 32'(timeout_flag), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    logic [39:0] mk;
    logic [7:0]  exp_b[$];
    logic [7:0]  eb;
    logic [7:0]  gb;

    sw = {32'h8E89BED6, 8'hAA};
    rst_n = 1'b0;
    enable = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    model_reset();
    reset_dut();

    // 1: clean lock, full packet, release
    send_sync('0, 1'b0);
    chk("t1_latency", 32'(sync_found), 32'(0));
    idle(1);
    chk("t1_sync", 32'(sync_found), 32'(1));
    chk("t1_marker", 32'(data_out), 32'h8E);
    n0 = got_q.size();
    for (int k = 0; k < MAX_BYTES; k++) begin
      eb = 8'($urandom);
      exp_b.push_back(eb);
      send_byte(eb, 1'b1);
    end
    chk("t1_last_sync", 32'(sync_found), 32'(1));
    chk("t1_last_dv", 32'(data_valid), 32'(1));
    idle(1);
    chk("t1_release", 32'(sync_found), 32'(0));
    chk("t1_nbytes", 32'(got_q.size() - n0), 32'(MAX_BYTES));
    for (int k = 0; k < MAX_BYTES; k++) begin
      chk("t1_byte", 32'(got_q[n0+k]), 32'(exp_b[k]));
    end
    chk("t1_lock", 32'(lock_count), 32'(1));

    // 2: one error locks, two errors do not
    drop();
    mk = '0;
    mk[13] = 1'b1;
    send_sync(mk, 1'b1);
    idle(1);
    chk("t2_lock1", 32'(sync_found), 32'(1));
    chk("t2_cnt1", 32'(lock_count), 32'(2));
    drop();
    n0 = got_q.size();
    mk[25] = 1'b1;
    send_sync(mk, 1'b1);
    idle(3);
    chk("t2_nolock", 32'(sync_found), 32'(0));
    chk("t2_cnt2", 32'(lock_count), 32'(2));
    chk("t2_nodv", 32'(got_q.size() - n0), 32'(0));

    // 3: timeout with a partial byte pending
    drop();
    send_sync('0, 1'b1);
    idle(1);
    n0 = got_q.size();
    for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1'b1);
    chk("t3_bytes", 32'(got_q.size() - n0), 32'(2));
    idle(TIMEOUT - 1);
    chk("t3_early_to", 32'(timeout_flag), 32'(0));
    chk("t3_still_lock", 32'(sync_found), 32'(1));
    idle(1);
    chk("t3_to", 32'(timeout_flag), 32'(1));
    chk("t3_unlock", 32'(sync_found), 32'(0));
    idle(4);
    chk("t3_pulse", 32'(timeout_flag), 32'(0));
    chk("t3_no_partial", 32'(got_q.size() - n0), 32'(2));
    chk("t3_lock", 32'(lock_count), 32'(3));

    // 4: enable drop beats byte completion and match
    drop();
    send_sync('0, 1'b1);
    idle(1);
    for (int k = 0; k < 9; k++) send_byte(8'($urandom), 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b1);
    cycle(1'b0, 1'b1, 1'($urandom));
    chk("t4_drop_sync", 32'(sync_found), 32'(0));
    chk("t4_drop_dv", 32'(data_valid), 32'(0));
    chk("t4_hold_cnt", 32'(lock_count), 32'(4));
    send_sync('0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("t4_match_blk", 32'(sync_found), 32'(0));
    chk("t4_match_cnt", 32'(lock_count), 32'(4));
    send_sync('0, 1'b1);
    idle(1);
    chk("t4_relock", 32'(sync_found), 32'(1));
    chk("t4_cnt", 32'(lock_count), 32'(5));

    // 5: asynchronous reset mid-packet, then re-arm
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b0);
    rst_n = 1'b0;
    bit_valid = 1'b0;
    #1;
    model_reset();
    chk("t5_sync", 32'(sync_found), 32'(0));
    chk("t5_dv", 32'(data_valid), 32'(0));
    chk("t5_dout", 32'(data_out), 32'(0));
    chk("t5_lock", 32'(lock_count), 32'(0));
    chk("t5_to", 32'(timeout_flag), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i < 40; i++) send_bit(sw[i], 1'b0);
    idle(2);
    chk("t5_39bits", 32'(sync_found), 32'(0));
    send_sync('0, 1'b0);
    idle(1);
    chk("t5_relock", 32'(sync_found), 32'(1));
    chk("t5_cnt", 32'(lock_count), 32'(1));

    // 6: bit every clock, first PDU bit in the match cycle
    drop();
    send_sync('0, 1'b0);
    n0 = got_q.size();
    for (int i = 0; i < MAX_BYTES * 8; i++) begin
      pdu[i] = 1'($urandom);
      send_bit(pdu[i], 1'b0);
    end
    chk("t6_count", 32'(got_q.size() - n0), 32'(MAX_BYTES + 1));
    chk("t6_marker", 32'(got_q[n0]), 32'h8E);
    gb = got_q[n0+1];
    chk("t6_first_bit", 32'(gb[0]), 32'(pdu[0]));
    for (int k = 0; k < MAX_BYTES; k++) begin
      for (int j = 0; j < 8; j++) eb[j] = pdu[8*k+j];
      chk("t6_byte", 32'(got_q[n0+1+k]), 32'(eb));
    end
    send_bit(1'($urandom), 1'b0);
    chk("t6_release", 32'(sync_found), 32'(0));
    for (int i = 0; i < 60; i++) send_bit(1'($urandom), 1'b0);

    // randomized soak, every clock checked against the model
    for (int it = 0; it < 10; it++) begin
      int nn;
      nn = $urandom_range(0, 50);
      for (int i = 0; i < nn; i++) begin
        cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom));
      end
      mk = '0;
      nn = $urandom_range(0, 2);
      for (int e = 0; e < nn; e++) mk[$urandom_range(0, 39)] = 1'b1;
      send_sync(mk, 1'b1);
      nn = $urandom_range(0, 45);
      for (int k = 0; k < nn; k++) send_byte(8'($urandom), 1'b1);
      case ($urandom_range(0, 2))
        0: idle(TIMEOUT + 6);
        1: drop();
        default: idle(2);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
